// File: rtl/qsys_serial_target_pkg.sv
// Shared frame layout and FSM encoding for the serial bridge target.
package qsys_serial_target_pkg;
  localparam int FRAME_BITS = 65;
  localparam int RW_BIT     = 64;
  localparam int ADDR_MSB   = 63;
  localparam int ADDR_LSB   = 32;
  localparam int DATA_MSB   = 31;
  localparam int DATA_LSB   = 0;
  localparam int RESP_BITS  = 32;
  localparam int CNT_W      = 7;
  localparam int R_W        = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RESP    = 3'd4
  } state_t;
endpackage

// File: rtl/qsys_serial_target_if.sv
// Serial link plus local register bus seen by the serial target.
interface qsys_serial_target_if #(parameter int ADDR_WIDTH = 8);
  logic                  sle, sdo, srdy, sdi;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [31:0]           reg_wdata, reg_rdata;
  logic                  reg_wr, reg_rd, reg_rdvalid;

  modport slave  (input  sle, sdo, reg_rdata, reg_rdvalid,
                  output srdy, sdi, reg_addr, reg_wdata, reg_wr, reg_rd);
  modport master (output sle, sdo, reg_rdata, reg_rdvalid,
                  input  srdy, sdi, reg_addr, reg_wdata, reg_wr, reg_rd);
endinterface

// File: rtl/qsys_serial_rx_shift.sv
// Command deserialiser: delays sle one cycle, shifts in sdo while the delayed
// enable is high and flags complete (65-sample) or short frames.
module qsys_serial_rx_shift
  import qsys_serial_target_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sle,
  input  logic                  sdo,
  input  logic                  en,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  sample,
  output logic                  frame_done,
  output logic                  short_frame
);
  logic                  sle_d1;
  logic [FRAME_BITS-2:0] shreg;
  logic [CNT_W-1:0]      cnt;

  // frame includes the bit being sampled this edge, so the top can latch the
  // whole command on the same edge the 65th sample is taken
  assign frame       = {shreg, sdo};
  assign sample      = sle_d1 && en && (cnt < CNT_W'(FRAME_BITS));
  assign frame_done  = sample && (cnt == CNT_W'(FRAME_BITS - 1));
  assign short_frame = !sle_d1 && en && (cnt != '0) && (cnt < CNT_W'(FRAME_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sle_d1 <= 1'b0;
      shreg  <= '0;
      cnt    <= '0;
    end else begin
      sle_d1 <= sle;
      if (sample) begin
        shreg <= frame[FRAME_BITS-2:0];
        cnt   <= cnt + 1'b1;
      end else if (!sle_d1) begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/qsys_serial_target.sv
// Far-end target of the serial bridge: decodes a command frame, performs one
// register access and serialises the 32-bit response back to the master.
module qsys_serial_target
  import qsys_serial_target_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 8,
  parameter int          RD_TIMEOUT   = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                 csi_MCLK_clk,
  input  logic                 rsi_MRST_reset_n,
  qsys_serial_target_if.slave  bus,
  output logic                 err_frame,
  output logic                 err_timeout
);
  state_t                 state, state_n;
  logic [FRAME_BITS-1:0]  frame;
  logic                   sample, frame_done, short_frame;
  logic [15:0]            tcnt;
  logic [R_W-1:0]         r, r_n;
  logic [RESP_BITS-1:0]   resp_sh;
  logic                   load_cmd, tmo_hit, shift_out;
  logic                   frame_unused;

  qsys_serial_rx_shift u_rx (
    .clk         (csi_MCLK_clk),
    .rst_n       (rsi_MRST_reset_n),
    .sle         (bus.sle),
    .sdo         (bus.sdo),
    .en          (state == ST_IDLE || state == ST_SHIFT),
    .frame       (frame),
    .sample      (sample),
    .frame_done  (frame_done),
    .short_frame (short_frame)
  );

  // upper address bits are don't-care on this link
  assign frame_unused = ^frame[ADDR_MSB:ADDR_LSB+ADDR_WIDTH];

  assign load_cmd  = (state == ST_SHIFT) && frame_done;
  assign tmo_hit   = (tcnt == 16'(RD_TIMEOUT - 1));
  assign shift_out = (state == ST_RESP) && (r != R_W'(RESP_BITS));

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (sample) state_n = ST_SHIFT;
      ST_SHIFT:   if (frame_done) state_n = ST_EXEC;
                  else if (short_frame) state_n = ST_IDLE;
      ST_EXEC:    state_n = bus.reg_wr ? ST_RESP : ST_RD_WAIT;
      ST_RD_WAIT: if (bus.reg_rdvalid || tmo_hit) state_n = ST_RESP;
      ST_RESP:    if (r == R_W'(RESP_BITS)) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
    r_n = (state == ST_RESP && state_n == ST_RESP) ? r + 1'b1 : '0;
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state         <= ST_IDLE;
      r             <= '0;
      tcnt          <= '0;
      resp_sh       <= '0;
      bus.reg_wr    <= 1'b0;
      bus.reg_rd    <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.srdy      <= 1'b0;
      bus.sdi       <= 1'b0;
      err_frame     <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state      <= state_n;
      r          <= r_n;
      bus.reg_wr <= load_cmd && frame[RW_BIT];
      bus.reg_rd <= load_cmd && !frame[RW_BIT];
      if (load_cmd) begin
        bus.reg_addr  <= frame[ADDR_LSB +: ADDR_WIDTH];
        bus.reg_wdata <= frame[DATA_MSB:DATA_LSB];
      end
      if (state == ST_EXEC) tcnt <= '0;
      else if (state == ST_RD_WAIT) tcnt <= tcnt + 1'b1;
      // valid data wins over a timeout landing on the same cycle
      if (state == ST_EXEC && bus.reg_wr) resp_sh <= '0;
      else if (state == ST_RD_WAIT && bus.reg_rdvalid) resp_sh <= bus.reg_rdata;
      else if (state == ST_RD_WAIT && tmo_hit) resp_sh <= TIMEOUT_DATA;
      else if (shift_out) resp_sh <= {resp_sh[RESP_BITS-2:0], 1'b0};
      if (state == ST_SHIFT && short_frame) err_frame <= 1'b1;
      if (state == ST_RD_WAIT && !bus.reg_rdvalid && tmo_hit) err_timeout <= 1'b1;
      // srdy covers r=0..31; sdi lags by one so the last bit lands as srdy falls
      bus.srdy <= (state_n == ST_RESP) && (r_n != R_W'(RESP_BITS));
      bus.sdi  <= shift_out && resp_sh[RESP_BITS-1];
    end
  end
endmodule

// File: tb/tb_qsys_serial_target.sv
// Directed + randomized bench: master/peripheral models drive the target and
// an address-indexed reference memory predicts every response word.
module tb_qsys_serial_target;
  localparam int RDT = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic err_frame, err_timeout;
  int   ncmp = 0, nerr = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] per_mem [256];
  logic [31:0] resp;

  qsys_serial_target_if #(.ADDR_WIDTH(8)) bus ();

  qsys_serial_target #(.ADDR_WIDTH(8), .RD_TIMEOUT(RDT), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
    .csi_MCLK_clk     (clk),
    .rsi_MRST_reset_n (rst_n),
    .bus              (bus),
    .err_frame        (err_frame),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input bit rw, input logic [31:0] addr, input logic [31:0] data);
    logic [64:0] f;
    f = {rw, addr, data};
    for (int i = 0; i <= 65; i++) begin
      @(negedge clk);
      bus.sle = (i < 65);
      bus.sdo = (i > 0) ? f[65-i] : 1'b0;
      bus.reg_rdvalid = 1'b0;
    end
  endtask

  // vdelay: cycles after reg_rd until rdvalid (0 = never); abort_r: RESP index to reset at
  task automatic do_txn(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                        input int vdelay, input int abort_r, output logic [31:0] rsp);
    int lat, exp_lat, nsrdy;
    logic [7:0]  ra;
    logic [31:0] exp_rsp;
    rsp = '0;
    send_frame(rw, addr, data);
    @(negedge clk);
    bus.sdo = 1'b0;
    chk("strobe_wr", 64'(bus.reg_wr), 64'(rw));
    chk("strobe_rd", 64'(bus.reg_rd), 64'(!rw));
    chk("reg_addr", 64'(bus.reg_addr), 64'(addr[7:0]));
    ra = bus.reg_addr;
    if (rw) begin
      chk("reg_wdata", 64'(bus.reg_wdata), 64'(data));
      per_mem[ra] = bus.reg_wdata;
      ref_mem[addr[7:0]] = data;
    end
    exp_rsp = rw ? 32'h0 : (vdelay > 0 ? ref_mem[addr[7:0]] : 32'hDEADBEEF);
    exp_lat = rw ? 1 : (vdelay > 0 ? vdelay + 1 : RDT + 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("strobe_1cyc", 64'(bus.reg_wr | bus.reg_rd), 64'(0));
      bus.reg_rdata = $urandom;
      bus.reg_rdvalid = 1'b0;
      if (!rw && vdelay > 0 && lat == vdelay) begin
        bus.reg_rdvalid = 1'b1;
        bus.reg_rdata = per_mem[ra];
      end else if (rw && lat == 1) begin
        bus.reg_rdvalid = 1'b1;  // stray valid outside RD_WAIT must be ignored
      end
    end while (!bus.srdy && lat < 300);
    chk("srdy_latency", 64'(lat), 64'(exp_lat));
    chk("sdi_r0", 64'(bus.sdi), 64'(0));
    nsrdy = 1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      bus.reg_rdvalid = 1'b0;
      if (k == abort_r) begin
        rst_n = 1'b0;
        #1;
        chk("rst_srdy", 64'(bus.srdy), 64'(0));
        chk("rst_sdi", 64'(bus.sdi), 64'(0));
        chk("rst_errs", 64'({err_frame, err_timeout}), 64'(0));
        chk("rst_addr", 64'(bus.reg_addr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (bus.srdy) nsrdy++;
      rsp = {rsp[30:0], bus.sdi};
    end
    chk("srdy_cycles", 64'(nsrdy), 64'(32));
    chk("resp_word", 64'(rsp), 64'(exp_rsp));
    @(negedge clk);
    chk("idle_srdy_sdi", 64'({bus.srdy, bus.sdi}), 64'(0));
  endtask

  initial begin
    int bad;
    logic [31:0] a, d;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; per_mem[i] = '0; end
    bus.sle = 0; bus.sdo = 0; bus.reg_rdata = 0; bus.reg_rdvalid = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({bus.srdy, bus.sdi, bus.reg_wr, bus.reg_rd, err_frame, err_timeout}), 64'(0));
    chk("reset_addr_data", 64'({bus.reg_addr, bus.reg_wdata}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write
    do_txn(1'b1, 32'h12, 32'hA5A50001, 0, -1, resp);
    // 2: read with valid 3 cycles after reg_rd
    per_mem[8'h40] = 32'hCAFEF00D; ref_mem[8'h40] = 32'hCAFEF00D;
    do_txn(1'b0, 32'h40, 32'h0, 3, -1, resp);
    chk("master_readdata", 64'(resp), 64'(32'hCAFEF00D));
    // 3: read timeout
    chk("err_timeout_pre", 64'(err_timeout), 64'(0));
    do_txn(1'b0, 32'h41, 32'h0, 0, -1, resp);
    chk("err_timeout_set", 64'(err_timeout), 64'(1));
    // 4: short frame, then a full write
    chk("err_frame_pre", 64'(err_frame), 64'(0));
    for (int i = 0; i < 20; i++) begin @(negedge clk); bus.sle = 1'b1; bus.sdo = 1'($urandom); end
    @(negedge clk); bus.sle = 1'b0; bus.sdo = 1'b0;
    bad = 0;
    repeat (80) begin @(negedge clk); if (bus.reg_wr || bus.reg_rd || bus.srdy) bad++; end
    chk("short_no_activity", 64'(bad), 64'(0));
    chk("err_frame_set", 64'(err_frame), 64'(1));
    do_txn(1'b1, 32'hFF00_0033, 32'h1234_5678, 0, -1, resp);
    // 5: reset at RESP r=10, then a fresh read
    do_txn(1'b1, 32'h77, 32'hF0F0_5A5A, 0, -1, resp);
    do_txn(1'b0, 32'h77, 32'h0, 2, 10, resp);
    chk("post_rst_errs", 64'({err_frame, err_timeout}), 64'(0));
    do_txn(1'b0, 32'h77, 32'h0, 2, -1, resp);
    // 6: back-to-back write then read of 0x01
    do_txn(1'b1, 32'h01, 32'h0BAD_CAFE, 0, -1, resp);
    do_txn(1'b0, 32'h01, 32'h0, 1, -1, resp);
    // randomized traffic over a small address window
    for (int n = 0; n < 14; n++) begin
      a = {$urandom_range(255, 0) << 8, 8'($urandom_range(15, 0))};
      d = $urandom;
      do_txn(1'($urandom_range(1, 0)), a, d, $urandom_range(6, 1), -1, resp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
